// File: rtl/gauss_frame_ctrl.sv
// Frame controller wrapped around a 3x3 filter: sequences one frame of pixels
// into the filter, counts the shrunken output frame and flags line/frame ends.
module gauss_frame_ctrl #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    input  logic [7:0] s_pixel,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       f_rst,
    output logic [7:0] f_pixel,
    output logic       f_valid,
    input  logic [7:0] fo_pixel,
    input  logic       fo_valid,
    output logic [7:0] m_pixel,
    output logic       m_valid,
    output logic       m_eol,
    output logic       m_eof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] IN_COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] IN_ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] OUT_COL_LAST = CW'(IMG_W - 3);
    localparam logic [RW-1:0] OUT_ROW_LAST = RW'(IMG_H - 3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t        r_state;
    logic          r_f_rst;
    logic [7:0]    r_f_pixel;
    logic          r_f_valid;
    logic          r_fv_d;
    logic          r_done;
    logic [CW-1:0] r_in_col;
    logic [RW-1:0] r_in_row;
    logic [CW-1:0] r_out_col;
    logic [RW-1:0] r_out_row;

    logic w_busy;
    logic w_xfer;
    logic w_abort;
    logic w_in_last;
    logic w_m_valid;
    logic w_m_eol;
    logic w_m_eof;

    assign w_busy    = (r_state == ST_RUN) || (r_state == ST_WAIT);
    assign s_ready   = (r_state == ST_RUN);
    assign w_xfer    = s_valid & s_ready;
    assign w_abort   = abort & w_busy;
    assign w_in_last = (r_in_col == IN_COL_LAST) && (r_in_row == IN_ROW_LAST);

    // fo_valid only counts when paired with a fresh filter input one cycle earlier,
    // so a filter that holds its valid high is not double counted.
    assign w_m_valid = fo_valid & r_fv_d & w_busy;
    assign w_m_eol   = w_m_valid & (r_out_col == OUT_COL_LAST);
    assign w_m_eof   = w_m_eol & (r_out_row == OUT_ROW_LAST);

    assign busy    = w_busy;
    assign done    = r_done;
    assign f_rst   = r_f_rst;
    assign f_pixel = r_f_pixel;
    assign f_valid = r_f_valid;
    assign m_pixel = fo_pixel;
    assign m_valid = w_m_valid;
    assign m_eol   = w_m_eol;
    assign m_eof   = w_m_eof;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_f_rst   <= 1'b1;
            r_f_pixel <= 8'd0;
            r_f_valid <= 1'b0;
            r_fv_d    <= 1'b0;
            r_done    <= 1'b0;
            r_in_col  <= '0;
            r_in_row  <= '0;
            r_out_col <= '0;
            r_out_row <= '0;
        end else begin
            r_f_rst   <= 1'b0;
            r_done    <= 1'b0;
            r_f_valid <= w_xfer & ~w_abort;
            r_fv_d    <= r_f_valid & ~w_abort;
            if (w_xfer) begin
                r_f_pixel <= s_pixel;
            end

            if (w_abort) begin
                // Cancel wins over any transfer or end-of-frame in the same cycle.
                r_state   <= ST_IDLE;
                r_f_rst   <= 1'b1;
                r_in_col  <= '0;
                r_in_row  <= '0;
                r_out_col <= '0;
                r_out_row <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state   <= ST_CLR;
                            r_f_rst   <= 1'b1;
                            r_in_col  <= '0;
                            r_in_row  <= '0;
                            r_out_col <= '0;
                            r_out_row <= '0;
                        end
                    end
                    ST_CLR: begin
                        r_state <= ST_RUN;
                    end
                    default: begin
                        if (w_xfer) begin
                            if (r_in_col == IN_COL_LAST) begin
                                r_in_col <= '0;
                                r_in_row <= r_in_row + RW'(1);
                            end else begin
                                r_in_col <= r_in_col + CW'(1);
                            end
                            if (w_in_last) begin
                                r_state <= ST_WAIT;
                            end
                        end
                        if (w_m_valid) begin
                            if (r_out_col == OUT_COL_LAST) begin
                                r_out_col <= '0;
                                r_out_row <= r_out_row + RW'(1);
                            end else begin
                                r_out_col <= r_out_col + CW'(1);
                            end
                        end
                        // End of frame also ends a RUN cut short by an early filter.
                        if (w_m_eof) begin
                            r_state   <= ST_IDLE;
                            r_done    <= 1'b1;
                            r_in_col  <= '0;
                            r_in_row  <= '0;
                            r_out_col <= '0;
                            r_out_row <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// Scoreboard bench for gauss_frame_ctrl on an 8x6 frame with a 1-cycle
// behavioural filter model that can optionally hold its output valid.
module tb_gauss_frame_ctrl;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int NPIX  = W * H;
    localparam int NBEAT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] s_pixel;
    logic       s_valid;
    logic       s_ready;
    logic       f_rst;
    logic [7:0] f_pixel;
    logic       f_valid;
    logic [7:0] fo_pixel = 8'd0;
    logic       fo_valid = 1'b0;
    logic [7:0] m_pixel;
    logic       m_valid;
    logic       m_eol;
    logic       m_eof;

    gauss_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .s_pixel  (s_pixel),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .f_rst    (f_rst),
        .f_pixel  (f_pixel),
        .f_valid  (f_valid),
        .fo_pixel (fo_pixel),
        .fo_valid (fo_valid),
        .m_pixel  (m_pixel),
        .m_valid  (m_valid),
        .m_eol    (m_eol),
        .m_eof    (m_eof)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] pix_q[$];
    logic [9:0] out_q[$];
    int  beats     = 0;
    int  eof_cnt   = 0;
    int  done_cnt  = 0;
    int  frst_cnt  = 0;
    int  cyc       = 0;
    int  eof_cyc   = -10;
    bit  hold_mode = 1'b0;
    int  fcol      = 0;
    int  frow      = 0;

    // Filter model: one-cycle latency, valid only for full 3x3 windows.
    always @(posedge clk) begin
        if (f_rst) begin
            fo_valid <= 1'b0;
            fcol     <= 0;
            frow     <= 0;
        end else if (f_valid) begin
            fo_valid <= (fcol >= 2) && (frow >= 2);
            fo_pixel <= f_pixel ^ 8'hA5;
            if ((fcol >= 2) && (frow >= 2))
                out_q.push_back({f_pixel ^ 8'hA5, fcol == W - 1, (fcol == W - 1) && (frow == H - 1)});
            if (fcol == W - 1) begin
                fcol <= 0;
                frow <= frow + 1;
            end else begin
                fcol <= fcol + 1;
            end
        end else begin
            fo_valid <= hold_mode & fo_valid;
        end
    end

    // Monitor: compares every filter-input and downstream beat against the queues.
    always @(negedge clk) begin
        logic [7:0] exp_pix;
        logic [9:0] exp_out;
        cyc++;
        if (f_rst) frst_cnt++;
        if (f_valid) begin
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL f_pixel_extra: got %0h, required no f_valid", f_pixel);
            end else begin
                exp_pix = pix_q.pop_front();
                if (f_pixel !== exp_pix) begin
                    errors++;
                    $display("FAIL f_pixel: got %0h, required %0h", f_pixel, exp_pix);
                end
            end
        end
        if (s_valid && s_ready && !abort) pix_q.push_back(s_pixel);
        if (m_valid) begin
            beats++;
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL m_beat_extra: got beat %0d, required none", beats);
            end else begin
                exp_out = out_q.pop_front();
                if ({m_pixel, m_eol, m_eof} !== exp_out) begin
                    errors++;
                    $display("FAIL m_beat %0d: got pix=%0h eol=%0b eof=%0b, required pix=%0h eol=%0b eof=%0b",
                             beats, m_pixel, m_eol, m_eof, exp_out[9:2], exp_out[1], exp_out[0]);
                end
            end
            if (m_eof) begin
                eof_cnt++;
                eof_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            checks++;
            if (cyc != eof_cyc + 1) begin
                errors++;
                $display("FAIL done_timing: got cycle %0d, required %0d", cyc, eof_cyc + 1);
            end
        end
    end

    task automatic clear_sb();
        pix_q.delete();
        out_q.delete();
        beats    = 0;
        eof_cnt  = 0;
        done_cnt = 0;
        frst_cnt = 0;
        eof_cyc  = -10;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic feed(input int n, input int pct, input int start_at, output int sent);
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 4000) begin
            s_valid = ($urandom_range(99) < pct);
            s_pixel = 8'($urandom);
            start   = (start_at >= 0) && (sent == start_at);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int guard;
        guard = 0;
        while (done_cnt == 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        ok = (done_cnt != 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_pixel = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, s_ready, done, f_valid, m_valid} !== 5'b0 || f_pixel !== 8'd0 || f_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got busy=%0b rdy=%0b done=%0b fv=%0b mv=%0b fpix=%0h frst=%0b, required 0/0/0/0/0/00/1",
                     busy, s_ready, done, f_valid, m_valid, f_pixel, f_rst);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (f_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_frst_hold: got %0b, required 1", f_rst);
        end
        @(posedge clk); #1;
        checks++;
        if (f_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got frst=%0b busy=%0b, required 0/0", f_rst, busy);
        end
        $display("test_reset complete");
    endtask

    task automatic test_frame(input string name, input int pct, input bit hold, input int start_at);
        int sent;
        bit ok;
        hold_mode = hold;
        clear_sb();
        do_start();
        feed(NPIX, pct, start_at, sent);
        checks++;
        if (sent != NPIX) begin
            errors++;
            $display("FAIL %s_transfers: got %0d, required %0d", name, sent, NPIX);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done, required done", name);
        end
        checks++;
        if (beats != NBEAT || eof_cnt != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL %s_counts: got beats=%0d eof=%0d done=%0d, required %0d/1/1",
                     name, beats, eof_cnt, done_cnt, NBEAT);
        end
        checks++;
        if (busy !== 1'b0 || frst_cnt != 1 || pix_q.size() != 0 || out_q.size() != 0) begin
            errors++;
            $display("FAIL %s_end_state: got busy=%0b frst_cycles=%0d pixq=%0d outq=%0d, required 0/1/0/0",
                     name, busy, frst_cnt, pix_q.size(), out_q.size());
        end
        hold_mode = 1'b0;
        $display("%s complete: %0d beats, %0d done", name, beats, done_cnt);
    endtask

    task automatic test_abort();
        int sent;
        clear_sb();
        do_start();
        feed(20, 100, -1, sent);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || f_rst !== 1'b1 || f_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b rdy=%0b frst=%0b fv=%0b, required 0/0/1/0",
                     busy, s_ready, f_rst, f_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (f_rst !== 1'b0) begin
            errors++;
            $display("FAIL abort_frst_pulse: got %0b, required 0", f_rst);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done=%0d busy=%0b, required 0/0", done_cnt, busy);
        end
        $display("test_abort complete");
        test_frame("abort_restart", 100, 1'b0, -1);
    endtask

    task automatic test_rst_in_wait();
        int sent;
        clear_sb();
        do_start();
        feed(NPIX, 100, -1, sent);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: got busy=%0b rdy=%0b, required 1/0", busy, s_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, s_ready, done, f_valid, m_valid} !== 5'b0 || f_pixel !== 8'd0 || f_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_values: got busy=%0b rdy=%0b done=%0b fv=%0b mv=%0b fpix=%0h frst=%0b, required 0/0/0/0/0/00/1",
                     busy, s_ready, done, f_valid, m_valid, f_pixel, f_rst);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (f_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_frst_hold: got %0b, required 1", f_rst);
        end
        @(posedge clk); #1;
        checks++;
        if (f_rst !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_frst_release: got %0b, required 0", f_rst);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_no_done: got done=%0d busy=%0b, required 0/0", done_cnt, busy);
        end
        $display("test_rst_in_wait complete");
    endtask

    initial begin
        test_reset();
        test_frame("test_full_frame", 100, 1'b0, -1);
        test_frame("test_random_valid", 50, 1'b0, -1);
        test_frame("test_hold_fo_valid", 40, 1'b1, -1);
        test_frame("test_start_in_run", 70, 1'b0, 10);
        test_abort();
        test_rst_in_wait();
        test_frame("test_back_to_back", 100, 1'b0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gauss_frame_ctrl.md
GAUSS_FRAME_CTRL -- requirements
Module: gauss_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 256, pixels per line; legal range 3..256.
REQ-002 Parameter IMG_H, default 256, lines per frame; legal range 3..511.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame start request; sampled only in IDLE.
REQ-006 abort  input  1  synchronous frame cancel; sampled in RUN and WAIT.
REQ-007 busy  output  1  high in RUN and WAIT.
REQ-008 done  output  1  one-cycle pulse when a frame completes.
REQ-009 s_pixel  input  8  upstream pixel.
REQ-010 s_valid  input  1  upstream pixel valid.
REQ-011 s_ready  output  1  controller accepts a pixel; a transfer occurs when s_valid and s_ready are both high.
REQ-012 f_rst  output  1  reset to the 3x3 filter; registered.
REQ-013 f_pixel  output  8  pixel to the filter; registered.
REQ-014 f_valid  output  1  pixel-valid strobe to the filter; registered.
REQ-015 fo_pixel  input  8  filter output pixel.
REQ-016 fo_valid  input  1  filter output valid.
REQ-017 m_pixel  output  8  downstream pixel, combinational copy of fo_pixel.
REQ-018 m_valid  output  1  downstream valid.
REQ-019 m_eol  output  1  high with the last m_valid beat of each output line.
REQ-020 m_eof  output  1  high with the final m_valid beat of the frame.

Function
REQ-021 States SHALL be IDLE, CLR, RUN and WAIT.
REQ-022 IDLE: start=1 -> CLR; f_rst=1 for exactly the one CLR cycle; CLR -> RUN unconditionally.
REQ-023 RUN: s_ready=1; all other states: s_ready=0.
REQ-024 f_pixel and f_valid SHALL register s_pixel and (s_valid & s_ready): one-cycle latency, with no pixel dropped or duplicated.
REQ-025 Input counters in_col (0..IMG_W-1) and in_row (0..IMG_H-1) SHALL advance per transfer; in_col wraps to 0 and increments in_row.
REQ-026 The transfer at in_col=IMG_W-1, in_row=IMG_H-1 SHALL move RUN -> WAIT in the same cycle.
REQ-027 Let fv_d be f_valid delayed one cycle. m_valid SHALL equal fo_valid & fv_d & busy, so a held fo_valid is never counted twice.
REQ-028 Output counters out_col (0..IMG_W-3) and out_row (0..IMG_H-3) SHALL advance per m_valid beat.
REQ-029 m_eol = m_valid & (out_col=IMG_W-3).
REQ-030 m_eof = m_eol & (out_row=IMG_H-3).
REQ-031 One frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) m_valid beats.
REQ-032 The m_eof beat SHALL move the controller to IDLE; done SHALL pulse on the following cycle.
REQ-033 If m_eof occurs while still in RUN (misbehaving filter), the controller SHALL still go to IDLE and pulse done.
REQ-034 abort=1 in RUN or WAIT -> IDLE next cycle: f_rst pulses one cycle, f_valid=0 and s_ready=0 from that cycle, no done, counters cleared.
REQ-035 abort takes priority over a simultaneous transfer or m_eof.
REQ-036 start outside IDLE SHALL be ignored; abort in IDLE or CLR SHALL be ignored.
REQ-037 Counters SHALL be wide enough for IMG_W=256 and IMG_H=511 without overflow.

Reset
REQ-038 rst=1 SHALL immediately force IDLE, s_ready=0, busy=0, done=0, f_valid=0, f_pixel=0, fv_d=0, m_valid=0 and all counters 0.
REQ-039 f_rst SHALL be 1 while rst=1 and for one cycle after rst deasserts.
REQ-040 rst mid-frame SHALL discard the frame with no done pulse.

Verification (IMG_W=8, IMG_H=6)
REQ-041 start, then 48 pixels with s_valid held high -> 24 m_valid beats, m_eol on beats 6/12/18/24, m_eof on beat 24, done one cycle later, busy low afterwards.
REQ-042 s_valid toggled randomly -> f_valid reproduces every accepted pixel one cycle late, in order; still 24 beats and one done.
REQ-043 abort after 20 transfers -> IDLE next cycle, one f_rst pulse, no done; a new start then gives a clean 24-beat frame.
REQ-044 start asserted during RUN -> no effect; frame completes normally.
REQ-045 rst asserted in WAIT -> outputs at reset values immediately, no done, f_rst high for one cycle after release.
REQ-046 fo_valid held high across s_valid gaps -> m_valid only on qualified cycles; beat count stays 24.
